barker_corr_param: RTL and testbench

BARKER_CORR_PARAM -- requirements
Module: barker_corr_param

---
 rtl/barker_corr_param.sv | 144 ++++++++++++++
 tb/tb_barker_corr_param.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/barker_corr_param.sv
// Streaming Barker-code matched filter (L = 7/11/13) with AXI-Stream style in/out handshakes.
// Define BARKER_CORR_PEAK_CNT_EN to add the o_peak_cnt peak counter output.
module barker_corr_param #(
    parameter int                       DATA_W   = 8,
    parameter int                       CODE_LEN = 11,
    parameter logic signed [DATA_W+3:0] THRESH   = (DATA_W + 4)'(600)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic signed [DATA_W-1:0] s_tdata,
    input  logic                     s_tvalid,
    input  logic                     s_tlast,
    output logic                     s_tready,
    output logic signed [DATA_W+3:0] m_tdata,
    output logic [1:0]               m_tuser,
    output logic                     m_tvalid,
    output logic                     m_tlast,
    input  logic                     m_tready
`ifdef BARKER_CORR_PEAK_CNT_EN
    ,
    output logic [15:0]              o_peak_cnt
`endif
);

    localparam int ACC_W  = DATA_W + 4;
    localparam int FILL_W = $clog2(CODE_LEN + 1);

    if (!(CODE_LEN == 7 || CODE_LEN == 11 || CODE_LEN == 13)) begin : g_bad_code_len
        $error("barker_corr_param: CODE_LEN must be 7, 11 or 13");
    end
    if (DATA_W < 2 || DATA_W > 16) begin : g_bad_data_w
        $error("barker_corr_param: DATA_W must be in 2..16");
    end

    // Code bits right-aligned, MSB is the first chip transmitted; '1' = +1, '0' = -1.
    function automatic logic [12:0] code_bits(input int len);
        case (len)
            7:       code_bits = {6'b0, 7'b1110010};
            11:      code_bits = {2'b0, 11'b11100010010};
            13:      code_bits = 13'b1111100110101;
            default: code_bits = '0;
        endcase
    endfunction

    localparam logic [12:0]             CODE       = code_bits(CODE_LEN);
    localparam logic signed [ACC_W-1:0] NEG_THRESH = -THRESH;
    localparam logic [FILL_W-1:0]       FILL_MAX   = FILL_W'(CODE_LEN);

    logic signed [DATA_W-1:0] r_win      [CODE_LEN];
    logic signed [DATA_W-1:0] w_win_next [CODE_LEN];
    logic [FILL_W-1:0]        r_fill;
    logic [FILL_W-1:0]        w_fill_next;
    logic                     w_accept;
    logic                     w_full;
    logic signed [ACC_W-1:0]  w_corr;
    logic signed [ACC_W-1:0]  w_term;
    logic [1:0]               w_user;

    // A new beat may enter whenever the single output slot is empty or being drained.
    assign s_tready = !m_tvalid || m_tready;
    assign w_accept = s_tvalid && s_tready;

    always_comb begin
        for (int j = 0; j < CODE_LEN - 1; j++) begin
            w_win_next[j] = r_win[j+1];
        end
        w_win_next[CODE_LEN-1] = s_tdata;
    end

    assign w_fill_next = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;
    assign w_full      = (w_fill_next == FILL_MAX);

    // Oldest sample w[0] is weighted by the code MSB, so an in-order code peaks when aligned.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned (latch).
        w_corr = '0;
        w_term = '0;
        for (int j = 0; j < CODE_LEN; j++) begin
            w_term = {{(ACC_W - DATA_W){w_win_next[j][DATA_W-1]}}, w_win_next[j]};
            w_corr = CODE[CODE_LEN-1-j] ? (w_corr + w_term) : (w_corr - w_term);
        end
    end

    always_comb begin
        w_user = 2'b00;
        if (w_full) begin
            w_user[0] = (w_corr >= THRESH);
            w_user[1] = (w_corr <= NEG_THRESH);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: the window is a handful of flops, not RAM, so it is cleared by reset like any register.
        if (i_rst) begin
            for (int j = 0; j < CODE_LEN; j++) begin
                r_win[j] <= '0;
            end
            r_fill <= '0;
        end else if (w_accept) begin
            if (s_tlast) begin
                for (int j = 0; j < CODE_LEN; j++) begin
                    r_win[j] <= '0;
                end
                r_fill <= '0;
            end else begin
                // NOTE: non-blocking assignments so every flop samples pre-edge values.
                r_win  <= w_win_next;
                r_fill <= w_fill_next;
            end
        end
    end

    // Output slot: a new accept overwrites the slot even while it is being drained (no bubble).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tuser  <= 2'b00;
            m_tlast  <= 1'b0;
        end else if (w_accept) begin
            m_tvalid <= 1'b1;
            m_tdata  <= w_corr;
            m_tuser  <= w_user;
            m_tlast  <= s_tlast;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

`ifdef BARKER_CORR_PEAK_CNT_EN
    logic [15:0] r_peak_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_peak_cnt <= '0;
        end else if (m_tvalid && m_tready && (m_tuser != 2'b00) && (r_peak_cnt != 16'hFFFF)) begin
            r_peak_cnt <= r_peak_cnt + 16'd1;
        end
    end

    assign o_peak_cnt = r_peak_cnt;
`endif

endmodule

// File: tb/tb_barker_corr_param.sv
// Self-checking bench: three correlators (L=11, 13, 7) share one input bus; each is checked
// every cycle against a per-instance sample-history model built from the code strings.
`timescale 1ns/1ps
module tb_barker_corr_param;

    localparam int DW = 8;
    localparam int AW = DW + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic signed [DW-1:0] s_tdata  = '0;
    logic                 s_tvalid = 1'b0;
    logic                 s_tlast  = 1'b0;
    logic                 m_tready = 1'b1;

    logic                 rdy0, rdy1, rdy2;
    logic signed [AW-1:0] dat0, dat1, dat2;
    logic [1:0]           usr0, usr1, usr2;
    logic                 vld0, vld1, vld2;
    logic                 lst0, lst1, lst2;
`ifdef BARKER_CORR_PEAK_CNT_EN
    logic [15:0]          pk0, pk1, pk2;
`endif

    barker_corr_param #(.DATA_W(DW), .CODE_LEN(11)) u_l11 (
        .i_clk(clk), .i_rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(rdy0),
        .m_tdata(dat0), .m_tuser(usr0), .m_tvalid(vld0), .m_tlast(lst0), .m_tready(m_tready)
`ifdef BARKER_CORR_PEAK_CNT_EN
        , .o_peak_cnt(pk0)
`endif
    );

    barker_corr_param #(.DATA_W(DW), .CODE_LEN(13)) u_l13 (
        .i_clk(clk), .i_rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(rdy1),
        .m_tdata(dat1), .m_tuser(usr1), .m_tvalid(vld1), .m_tlast(lst1), .m_tready(1'b1)
`ifdef BARKER_CORR_PEAK_CNT_EN
        , .o_peak_cnt(pk1)
`endif
    );

    barker_corr_param #(.DATA_W(DW), .CODE_LEN(7), .THRESH(12'sd400)) u_l7 (
        .i_clk(clk), .i_rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(rdy2),
        .m_tdata(dat2), .m_tuser(usr2), .m_tvalid(vld2), .m_tlast(lst2), .m_tready(1'b1)
`ifdef BARKER_CORR_PEAK_CNT_EN
        , .o_peak_cnt(pk2)
`endif
    );

    logic                 o_rdy [3];
    logic signed [AW-1:0] o_dat [3];
    logic [1:0]           o_usr [3];
    logic                 o_vld [3];
    logic                 o_lst [3];
    assign o_rdy[0] = rdy0; assign o_rdy[1] = rdy1; assign o_rdy[2] = rdy2;
    assign o_dat[0] = dat0; assign o_dat[1] = dat1; assign o_dat[2] = dat2;
    assign o_usr[0] = usr0; assign o_usr[1] = usr1; assign o_usr[2] = usr2;
    assign o_vld[0] = vld0; assign o_vld[1] = vld1; assign o_vld[2] = vld2;
    assign o_lst[0] = lst0; assign o_lst[1] = lst1; assign o_lst[2] = lst2;
`ifdef BARKER_CORR_PEAK_CNT_EN
    logic [15:0] o_pk [3];
    assign o_pk[0] = pk0; assign o_pk[1] = pk1; assign o_pk[2] = pk2;
`endif

    // Reference model: last L accepted samples (oldest first), fill count, one pending result.
    string nm    [3] = '{"L11", "L13", "L7"};
    string codes [3] = '{"11100010010", "1111100110101", "1110010"};
    int    lens  [3] = '{11, 13, 7};
    int    thr   [3] = '{600, 600, 400};
    int    hist  [3][13];
    int    fill  [3];
    bit    pv    [3];
    int    pdata [3];
    int    puser [3];
    bit    plast [3];
    int    pcnt  [3];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic signed [31:0] got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int chip(input int i, input int k, input int amp);
        string c;
        c = codes[i];
        return (c[k] == "1") ? amp : -amp;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 13; j++) hist[i][j] = 0;
            fill[i] = 0; pv[i] = 1'b0; pdata[i] = 0; puser[i] = 0; plast[i] = 1'b0; pcnt[i] = 0;
        end
    endtask

    task automatic step(input int i, input bit vld, input int data, input bit last, input bit rdy);
        bit    exp_rdy;
        int    n;
        int    corr;
        string c;
        exp_rdy = !pv[i] || rdy;
        check({nm[i], ".s_tready"}, o_rdy[i], exp_rdy);
        check({nm[i], ".m_tvalid"}, o_vld[i], pv[i]);
        if (pv[i]) begin
            check({nm[i], ".m_tdata"}, o_dat[i], pdata[i]);
            check({nm[i], ".m_tuser"}, o_usr[i], puser[i]);
            check({nm[i], ".m_tlast"}, o_lst[i], plast[i]);
        end
`ifdef BARKER_CORR_PEAK_CNT_EN
        check({nm[i], ".o_peak_cnt"}, o_pk[i], pcnt[i]);
`endif
        if (pv[i] && rdy) begin
            if (puser[i] != 0 && pcnt[i] < 65535) pcnt[i]++;
            pv[i] = 1'b0;
        end
        if (vld && exp_rdy) begin
            n = lens[i];
            c = codes[i];
            for (int j = 0; j < n - 1; j++) hist[i][j] = hist[i][j+1];
            hist[i][n-1] = data;
            if (fill[i] < n) fill[i]++;
            corr = 0;
            for (int j = 0; j < n; j++) corr += (c[j] == "1") ? hist[i][j] : -hist[i][j];
            pdata[i] = corr;
            puser[i] = 0;
            if (fill[i] == n) puser[i] = ((corr >= thr[i]) ? 1 : 0) + ((corr <= -thr[i]) ? 2 : 0);
            plast[i] = last;
            pv[i]    = 1'b1;
            if (last) begin
                for (int j = 0; j < 13; j++) hist[i][j] = 0;
                fill[i] = 0;
            end
        end
    endtask

    task automatic cycle(input bit vld, input int data, input bit last, input bit rdy);
        @(negedge clk);
        s_tvalid = vld;
        s_tdata  = DW'(data);
        s_tlast  = last;
        m_tready = rdy;
        #1;
        step(0, vld, data, last, rdy);
        step(1, vld, data, last, 1'b1);
        step(2, vld, data, last, 1'b1);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear before any edge.
    task automatic do_reset();
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check({nm[i], ".rst_m_tvalid"}, o_vld[i], 0);
            check({nm[i], ".rst_m_tdata"},  o_dat[i], 0);
            check({nm[i], ".rst_m_tuser"},  o_usr[i], 0);
            check({nm[i], ".rst_m_tlast"},  o_lst[i], 0);
            check({nm[i], ".rst_s_tready"}, o_rdy[i], 1);
`ifdef BARKER_CORR_PEAK_CNT_EN
            check({nm[i], ".rst_peak_cnt"}, o_pk[i], 0);
`endif
        end
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Directed look at an instance's result one edge after its triggering sample was driven.
    task automatic expect_out(input int i, input int d, input int u);
        @(posedge clk);
        #1;
        check({nm[i], ".det_valid"}, o_vld[i], 1);
        check({nm[i], ".det_data"},  o_dat[i], d);
        check({nm[i], ".det_user"},  o_usr[i], u);
    endtask

    initial begin
        model_clear();
        do_reset();

        // Matched +/-64 stream, three code periods, then two sign-inverted periods.
        for (int rep = 0; rep < 3; rep++) begin
            for (int k = 0; k < 11; k++) cycle(1'b1, chip(0, k, 64), 1'b0, 1'b1);
            if (rep == 0) expect_out(0, 704, 1);
        end
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 11; k++) cycle(1'b1, chip(0, k, -64), 1'b0, 1'b1);
            if (rep == 0) expect_out(0, -704, 2);
        end

        // Downstream stall of three cycles in the middle of a continuous stream.
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, chip(0, k % 11, 64), 1'b0, !(k >= 8 && k <= 10));
        end

        // Full-scale samples: largest positive and negative correlations.
        for (int k = 0; k < 11; k++) cycle(1'b1, (chip(0, k, 1) > 0) ? 127 : -128, 1'b0, 1'b1);
        for (int k = 0; k < 11; k++) cycle(1'b1, (chip(0, k, 1) > 0) ? -128 : 127, 1'b0, 1'b1);

        // Random data, gaps, backpressure and frame ends.
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) - 128,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
        end

        // Frame end on the 5th matching sample, then a fresh full code.
        do_reset();
        for (int k = 0; k < 5; k++) cycle(1'b1, chip(0, k, 64), k == 4, 1'b1);
        for (int k = 0; k < 11; k++) cycle(1'b1, chip(0, k, 64), 1'b0, 1'b1);
        expect_out(0, 704, 1);

        // Reset mid-frame with a result pending, then a fresh full code.
        for (int k = 0; k < 6; k++) cycle(1'b1, chip(0, k, 64), 1'b0, 1'b1);
        do_reset();
        for (int k = 0; k < 11; k++) cycle(1'b1, chip(0, k, 64), 1'b0, 1'b1);
        expect_out(0, 704, 1);

        // L=13 matching code.
        do_reset();
        for (int k = 0; k < 13; k++) cycle(1'b1, chip(1, k, 64), 1'b0, 1'b1);
        expect_out(1, 832, 1);

        // L=7: seven consecutive code periods.
        do_reset();
        for (int rep = 0; rep < 7; rep++) begin
            for (int k = 0; k < 7; k++) cycle(1'b1, chip(2, k, 64), 1'b0, 1'b1);
        end
        cycle(1'b0, 0, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b1);
`ifdef BARKER_CORR_PEAK_CNT_EN
        check("L7.peak_cnt_total", o_pk[2], 7);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
